age_ctr: RTL and testbench
==========================

AGE_CTR -- requirements
Module: age_ctr

Interface
REQ-001 Parameter k, default 3: width of each per-line age counter.
REQ-002 Parameter j, default 2: width of the set access counter used for age granularity.
REQ-003 Parameter A, default 2: age granularity, i.e. accesses per age tick; legal range 1..2**j.
REQ-004 Parameter accessCtrWidth, default 13: width of the EVA epoch access counter.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low (rst=0 resets on the next rising clk edge).
REQ-007 access  input  1  one set access this cycle (hit or miss); hit, fill and access_addr are ignored when 0.
REQ-008 hit  input  1  qualifies access; 1 = hit, 0 = miss with fill into access_addr.
REQ-009 access_addr  input  5  line index (0..31) being hit or filled.
REQ-010 age_1D  output  32*k  registered ages; line n occupies bits [n*k +: k].
REQ-011 update_EVA  output  1  one-cycle registered pulse at the end of each epoch.
REQ-012 evict_valid  output  1  one-cycle registered pulse, the cycle after a fill.
REQ-013 evict_age  output  k  age of the replaced line, valid while evict_valid=1.

Function
REQ-014 Registered outputs: age_1D during an access cycle holds the pre-access ages; this lets the downstream hit counter bin the hit by the line's pre-access age in the same cycle.
REQ-015 Counters: set_ctr (j bits) increments on each cycle with access=1.
- When access=1 and set_ctr==A-1, set_ctr wraps to 0 and age_tick=1 for that cycle.
- With A=1, every access produces age_tick=1.
REQ-016 Age tick: on age_tick, every line except access_addr increments its age by 1, saturating at 2**k-1 (no wrap).
REQ-017 Accessed line: on access=1, the age of line access_addr is set to 0 for both hit and fill. This takes priority over age_tick for that line.
REQ-018 Fill: on access=1 and hit=0, next cycle evict_valid=1 and evict_age holds the pre-access age of line access_addr.
- On any other cycle, evict_valid=0 and evict_age holds its last value.
REQ-019 Epoch counter: access_ctr (accessCtrWidth bits) increments on each access.
- When access=1 and access_ctr is all-ones, access_ctr wraps to 0 and update_EVA=1 on the next cycle only.
REQ-020 update_EVA does not clear ages, set_ctr or evict outputs.
REQ-021 Back-to-back accesses on consecutive cycles are fully supported; each access sees the result of the previous one.
REQ-022 The same line may be accessed on consecutive cycles; its age stays 0.
REQ-023 access=0 cycles hold all state unchanged.
REQ-024 An access_addr value is always in range 0..31; there are no undefined lines.

Reset
REQ-025 With rst=0 at a rising edge, the block resets as follows, regardless of access, and any in-flight pulse is cancelled:
- all 32 ages = 0
- set_ctr = 0, access_ctr = 0
- update_EVA = 0, evict_valid = 0, evict_age = 0
REQ-026 On the first edge after rst returns to 1, normal operation starts with all counters at 0.

Verification (defaults k=3, A=2, accessCtrWidth=13)
REQ-027 Aging: after reset, 4 hits to line 0 -> line 0 age=0; lines 1..31 age=2; no evict_valid; update_EVA=0.
REQ-028 Saturation: 20 hits to line 5 -> all other lines age=7 (saturated, not wrapped); line 5 age=0.
REQ-029 Fill/evict: age line 9 to 3, then access=1, hit=0, addr=9 -> next cycle evict_valid=1, evict_age=3, line 9 age=0; cycle after, evict_valid=0.
REQ-030 Epoch: 8192 consecutive accesses -> update_EVA=1 exactly one cycle after the 8192nd access and never before; ages unaffected by the pulse.
REQ-031 Idle/ignore: access=0 with hit=0 and addr toggling for 10 cycles -> no state change, no pulses.
REQ-032 Reset mid-operation: rst=0 on the same edge as a fill, with set_ctr=1 -> all ages 0, evict_valid stays 0, and the next 2 accesses produce exactly one age tick.

Source files
------------

// File: rtl/age_ctr.sv
// rtl/age_ctr.sv - per-line age counters with access-granular aging, fill eviction report and EVA epoch pulse
module age_ctr #(
    parameter int k              = 3,
    parameter int j              = 2,
    parameter int A              = 2,
    parameter int accessCtrWidth = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              access,
    input  logic              hit,
    input  logic [4:0]        access_addr,
    output logic [32*k-1:0]   age_1D,
    output logic              update_EVA,
    output logic              evict_valid,
    output logic [k-1:0]      evict_age
);

    localparam logic [k-1:0] AGE_MAX  = '1;
    localparam logic [j-1:0] SET_LAST = j'(A - 1);

    logic [j-1:0]              set_ctr;
    logic [accessCtrWidth-1:0] access_ctr;
    logic                      age_tick;
    logic [k-1:0]              cur_age;

    assign age_tick = access && (set_ctr == SET_LAST);
    assign cur_age  = age_1D[int'(access_addr)*k +: k];

    // Ages are registered, so during an access cycle age_1D still shows the
    // pre-access ages; the evicted age is captured from that same view.
    always_ff @(posedge clk) begin
        if (!rst) begin
            age_1D      <= '0;
            set_ctr     <= '0;
            access_ctr  <= '0;
            update_EVA  <= 1'b0;
            evict_valid <= 1'b0;
            evict_age   <= '0;
        end else begin
            update_EVA  <= access && (&access_ctr);
            evict_valid <= access && !hit;
            if (access) begin
                set_ctr    <= age_tick ? '0 : set_ctr + 1'b1;
                access_ctr <= access_ctr + 1'b1;
                if (!hit) begin
                    evict_age <= cur_age;
                end
                for (int n = 0; n < 32; n++) begin
                    if (n == int'(access_addr)) begin
                        age_1D[n*k +: k] <= '0;
                    end else if (age_tick && (age_1D[n*k +: k] != AGE_MAX)) begin
                        age_1D[n*k +: k] <= age_1D[n*k +: k] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_age_ctr.sv
// tb/tb_age_ctr.sv - self-checking bench for age_ctr against an arithmetic reference model
module tb_age_ctr;

    localparam int K      = 3;
    localparam int A      = 2;
    localparam int EPOCH  = 8192;
    localparam int AGEMAX = 7;

    logic          clk;
    logic          rst;
    logic          access;
    logic          hit;
    logic [4:0]    access_addr;
    logic [32*K-1:0] age_1D;
    logic          update_EVA;
    logic          evict_valid;
    logic [K-1:0]  evict_age;

    int n_cmp = 0;
    int n_bad = 0;

    int m_age [32];
    int m_acc;
    bit m_upd;
    bit m_ev;
    int m_ev_age;

    age_ctr #(.k(K), .j(2), .A(A), .accessCtrWidth(13)) dut (
        .clk        (clk),
        .rst        (rst),
        .access     (access),
        .hit        (hit),
        .access_addr(access_addr),
        .age_1D     (age_1D),
        .update_EVA (update_EVA),
        .evict_valid(evict_valid),
        .evict_age  (evict_age)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dut_age(int n);
        return int'(age_1D[n*K +: K]);
    endfunction

    // Model: ticks and epochs follow from the running access count since reset.
    task automatic model_step(bit r, bit a, bit h, int addr);
        bit tick;
        if (!r) begin
            foreach (m_age[n]) m_age[n] = 0;
            m_acc = 0; m_upd = 0; m_ev = 0; m_ev_age = 0;
            return;
        end
        m_upd = 0;
        m_ev  = 0;
        if (a) begin
            tick  = ((m_acc + 1) % A) == 0;
            m_upd = ((m_acc + 1) % EPOCH) == 0;
            if (!h) begin
                m_ev     = 1;
                m_ev_age = m_age[addr];
            end
            for (int n = 0; n < 32; n++) begin
                if (n == addr) m_age[n] = 0;
                else if (tick && m_age[n] < AGEMAX) m_age[n] = m_age[n] + 1;
            end
            m_acc = m_acc + 1;
        end
    endtask

    task automatic step(bit a, bit h, int addr);
        access      = a;
        hit         = h;
        access_addr = 5'(addr);
        @(posedge clk);
        model_step(rst, a, h, addr);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step(1'b1, 1'($urandom_range(1, 0)), int'($urandom_range(31, 0)));
        rst = 1'b1;
        for (int n = 0; n < 32; n++) begin
            n_cmp++;
            if (dut_age(n) !== 0) begin
                n_bad++;
                $display("FAIL reset_age[%0d]: got %0d expected 0", n, dut_age(n));
            end
        end
        n_cmp++;
        if (update_EVA !== 1'b0 || evict_valid !== 1'b0 || evict_age !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got upd=%b ev=%b age=%0d expected 0/0/0", update_EVA, evict_valid, evict_age);
        end
    endtask

    task automatic test_aging;
        rst = 1'b0; step(1'b0, 1'b0, 0); rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 0);
            n_cmp++;
            if (evict_valid !== 1'b0 || update_EVA !== 1'b0) begin
                n_bad++;
                $display("FAIL aging_pulses[%0d]: got ev=%b upd=%b expected 0/0", i, evict_valid, update_EVA);
            end
        end
        for (int n = 0; n < 32; n++) begin
            n_cmp++;
            if (dut_age(n) !== ((n == 0) ? 0 : 2)) begin
                n_bad++;
                $display("FAIL aging_age[%0d]: got %0d expected %0d", n, dut_age(n), (n == 0) ? 0 : 2);
            end
        end
    endtask

    task automatic test_saturation;
        rst = 1'b0; step(1'b0, 1'b0, 0); rst = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 5);
        for (int n = 0; n < 32; n++) begin
            n_cmp++;
            if (dut_age(n) !== ((n == 5) ? 0 : AGEMAX)) begin
                n_bad++;
                $display("FAIL sat_age[%0d]: got %0d expected %0d", n, dut_age(n), (n == 5) ? 0 : AGEMAX);
            end
        end
    endtask

    task automatic test_fill_evict;
        rst = 1'b0; step(1'b0, 1'b0, 0); rst = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 0);
        n_cmp++;
        if (dut_age(9) !== 3) begin
            n_bad++;
            $display("FAIL evict_preage: got %0d expected 3", dut_age(9));
        end
        step(1'b1, 1'b0, 9);
        n_cmp++;
        if (evict_valid !== 1'b1 || evict_age !== 3'd3 || dut_age(9) !== 0) begin
            n_bad++;
            $display("FAIL evict_pulse: got ev=%b age=%0d line9=%0d expected 1/3/0", evict_valid, evict_age, dut_age(9));
        end
        step(1'b0, 1'b0, 9);
        n_cmp++;
        if (evict_valid !== 1'b0 || evict_age !== 3'd3) begin
            n_bad++;
            $display("FAIL evict_after: got ev=%b age=%0d expected 0/3", evict_valid, evict_age);
        end
    endtask

    task automatic test_idle;
        int snap [32];
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(1, 0)), int'($urandom_range(31, 0)));
        foreach (snap[n]) snap[n] = m_age[n];
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, (i % 2) ? 31 : i);
            if (i > 0) begin
                n_cmp++;
                if (evict_valid !== 1'b0 || update_EVA !== 1'b0) begin
                    n_bad++;
                    $display("FAIL idle_pulses[%0d]: got ev=%b upd=%b expected 0/0", i, evict_valid, update_EVA);
                end
            end
            for (int n = 0; n < 32; n++) begin
                n_cmp++;
                if (dut_age(n) !== snap[n]) begin
                    n_bad++;
                    $display("FAIL idle_age[%0d]: got %0d expected %0d", n, dut_age(n), snap[n]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'($urandom_range(1, 0)), 12);
            n_cmp++;
            if (dut_age(12) !== 0) begin
                n_bad++;
                $display("FAIL b2b_age[%0d]: got %0d expected 0", i, dut_age(12));
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), int'($urandom_range(31, 0)));
            n_cmp++;
            if (update_EVA !== m_upd || evict_valid !== m_ev || int'(evict_age) !== m_ev_age) begin
                n_bad++;
                $display("FAIL rand_outputs[%0d]: got upd=%b ev=%b age=%0d expected %b/%b/%0d",
                         i, update_EVA, evict_valid, evict_age, m_upd, m_ev, m_ev_age);
            end
            for (int n = 0; n < 32; n++) begin
                n_cmp++;
                if (dut_age(n) !== m_age[n]) begin
                    n_bad++;
                    $display("FAIL rand_age[%0d][%0d]: got %0d expected %0d", i, n, dut_age(n), m_age[n]);
                end
            end
        end
    endtask

    task automatic test_epoch;
        rst = 1'b0; step(1'b0, 1'b0, 0); rst = 1'b1;
        for (int i = 0; i < EPOCH; i++) begin
            step(1'b1, 1'($urandom_range(1, 0)), int'($urandom_range(31, 0)));
            n_cmp++;
            if (update_EVA !== (i == EPOCH - 1)) begin
                n_bad++;
                $display("FAIL epoch_pulse[%0d]: got %b expected %b", i, update_EVA, (i == EPOCH - 1));
            end
        end
        step(1'b0, 1'b0, 0);
        n_cmp++;
        if (update_EVA !== 1'b0) begin
            n_bad++;
            $display("FAIL epoch_after: got %b expected 0", update_EVA);
        end
        for (int n = 0; n < 32; n++) begin
            n_cmp++;
            if (dut_age(n) !== m_age[n]) begin
                n_bad++;
                $display("FAIL epoch_age[%0d]: got %0d expected %0d", n, dut_age(n), m_age[n]);
            end
        end
    endtask

    task automatic test_reset_mid;
        rst = 1'b0; step(1'b0, 1'b0, 0); rst = 1'b1;
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 0);
        rst = 1'b0;
        step(1'b1, 1'b0, 7);
        rst = 1'b1;
        n_cmp++;
        if (evict_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_evict: got %b expected 0", evict_valid);
        end
        for (int n = 0; n < 32; n++) begin
            n_cmp++;
            if (dut_age(n) !== 0) begin
                n_bad++;
                $display("FAIL rstmid_age[%0d]: got %0d expected 0", n, dut_age(n));
            end
        end
        step(1'b1, 1'b1, 3);
        n_cmp++;
        if (dut_age(0) !== 0 || evict_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_first: got line0=%0d ev=%b expected 0/0", dut_age(0), evict_valid);
        end
        step(1'b1, 1'b1, 3);
        n_cmp++;
        if (dut_age(0) !== 1 || dut_age(31) !== 1 || dut_age(3) !== 0) begin
            n_bad++;
            $display("FAIL rstmid_tick: got l0=%0d l31=%0d l3=%0d expected 1/1/0", dut_age(0), dut_age(31), dut_age(3));
        end
    endtask

    initial begin
        rst         = 1'b0;
        access      = 1'b0;
        hit         = 1'b0;
        access_addr = '0;
        foreach (m_age[n]) m_age[n] = 0;
        m_acc = 0; m_upd = 0; m_ev = 0; m_ev_age = 0;
        @(negedge clk);
        test_reset;
        test_aging;
        test_saturation;
        test_fill_evict;
        test_idle;
        test_back_to_back;
        test_random;
        test_epoch;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
